// File: rtl/bcd_to_comp2_if.sv
// Digit-entry bus between the keypad/entry logic (master) and the
// BCD-to-two's-complement encoder (slave).
interface bcd_to_comp2_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       sign;
  logic       enter;
  logic       clear;
  logic [7:0] out;
  logic       out_valid;
  logic       overflow;
  logic       busy;
  logic [1:0] ndigits;

  modport master (
    output digit_valid, digit, sign, enter, clear,
    input  out, out_valid, overflow, busy, ndigits
  );

  modport slave (
    input  digit_valid, digit, sign, enter, clear,
    output out, out_valid, overflow, busy, ndigits
  );
endinterface

// File: rtl/bcd_to_comp2.sv
// Sequential decimal-entry encoder: accumulates up to three BCD digits and,
// on enter, emits the range-checked 8-bit two's-complement value.
module bcd_to_comp2 (
  input  logic           clk,
  input  logic           reset_n,
  bcd_to_comp2_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [9:0] acc_r, acc_s;
  logic [1:0] cnt_r, cnt_s;
  logic       sgn_r, sgn_s;
  logic [7:0] out_r, out_s;
  logic       out_valid_r, out_valid_s;
  logic       overflow_r, overflow_s;
  logic       busy_r, busy_s;
  logic       digit_ok_s;

  function automatic logic is_overflow(input logic [9:0] mag, input logic neg);
    if (neg) begin
      is_overflow = (mag > 10'd128);
    end else begin
      is_overflow = (mag > 10'd127);
    end
  endfunction

  // Negation is invert-plus-one in 8 bits, so -0 wraps to 0 and -128 to 8'h80.
  function automatic logic [7:0] to_comp2(input logic [7:0] mag, input logic neg);
    if (neg) begin
      to_comp2 = (~mag) + 8'd1;
    end else begin
      to_comp2 = mag;
    end
  endfunction

  assign digit_ok_s = bus.digit_valid && (bus.digit <= 4'd9);

  // Next-state and next-output logic; priority is clear > enter > digit.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    sgn_s       = sgn_r;
    out_s       = out_r;
    out_valid_s = out_valid_r;
    overflow_s  = overflow_r;

    case (state_r)
      ST_IDLE, ST_ACCUM: begin
        if (bus.clear) begin
          state_s     = ST_IDLE;
          acc_s       = 10'd0;
          cnt_s       = 2'd0;
          out_valid_s = 1'b0;
          overflow_s  = 1'b0;
        end else if (bus.enter) begin
          sgn_s   = bus.sign;
          state_s = ST_CONVERT;
        end else if (digit_ok_s && (cnt_r != 2'd3)) begin
          acc_s   = (acc_r << 3) + (acc_r << 1) + {6'd0, bus.digit};
          cnt_s   = cnt_r + 2'd1;
          state_s = ST_ACCUM;
        end else begin
          state_s = state_r;
        end
      end

      ST_CONVERT: begin
        overflow_s  = is_overflow(acc_r, sgn_r);
        if (is_overflow(acc_r, sgn_r)) begin
          out_s = 8'h00;
        end else begin
          out_s = to_comp2(acc_r[7:0], sgn_r);
        end
        out_valid_s = 1'b1;
        state_s     = ST_DONE;
      end

      ST_DONE: begin
        if (bus.clear) begin
          state_s     = ST_IDLE;
          acc_s       = 10'd0;
          cnt_s       = 2'd0;
          out_valid_s = 1'b0;
          overflow_s  = 1'b0;
        end else if (bus.enter) begin
          // enter outranks digit_valid even though it has no effect here
          state_s = state_r;
        end else if (digit_ok_s) begin
          acc_s       = {6'd0, bus.digit};
          cnt_s       = 2'd1;
          state_s     = ST_ACCUM;
          out_valid_s = 1'b0;
          overflow_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      default: begin
        state_s     = ST_IDLE;
        acc_s       = 10'd0;
        cnt_s       = 2'd0;
        out_valid_s = 1'b0;
        overflow_s  = 1'b0;
      end
    endcase

    busy_s = (state_s == ST_CONVERT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= 10'd0;
      cnt_r       <= 2'd0;
      sgn_r       <= 1'b0;
      out_r       <= 8'h00;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      sgn_r       <= sgn_s;
      out_r       <= out_s;
      out_valid_r <= out_valid_s;
      overflow_r  <= overflow_s;
      busy_r      <= busy_s;
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.overflow  = overflow_r;
  assign bus.busy      = busy_r;
  assign bus.ndigits   = cnt_r;

endmodule

// File: tb/tb_bcd_to_comp2.sv
// Scoreboard bench for bcd_to_comp2: directed cases followed by random
// stimulus, checked against an integer-arithmetic entry model.
module tb_bcd_to_comp2;

  logic clk;
  logic reset_n;
  bcd_to_comp2_if bus ();

  bcd_to_comp2 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];

  // model of the entry: number of digits, decimal magnitude, phase flags
  int         m_cnt  = 0;
  int         m_mag  = 0;
  bit         m_conv = 1'b0;
  bit         m_done = 1'b0;
  bit         m_ovf  = 1'b0;
  logic [7:0] m_out  = 8'h00;
  logic [8:0] pend   = 9'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_result(input int mag, input bit neg);
    int v;
    v = neg ? -mag : mag;
    if (v > 127 || v < -128) return {1'b1, 8'h00};
    return {1'b0, v[7:0]};
  endfunction

  task automatic model_step(input bit dv, input int d, input bit s, input bit en, input bit cl);
    if (m_conv) begin
      m_conv = 1'b0;
      m_done = 1'b1;
      m_out  = pend[7:0];
      m_ovf  = pend[8];
    end else if (cl) begin
      m_cnt  = 0;
      m_mag  = 0;
      m_done = 1'b0;
      m_ovf  = 1'b0;
    end else if (en) begin
      if (!m_done) begin
        pend   = ref_result(m_mag, s);
        exp_q.push_back(pend);
        m_conv = 1'b1;
      end
    end else if (dv && d <= 9) begin
      if (m_done) begin
        m_mag  = d;
        m_cnt  = 1;
        m_done = 1'b0;
        m_ovf  = 1'b0;
      end else if (m_cnt < 3) begin
        m_mag = m_mag * 10 + d;
        m_cnt++;
      end
    end
  endtask

  task automatic check_state();
    chk("ndigits",   bus.ndigits,   m_cnt);
    chk("busy",      bus.busy,      m_conv);
    chk("out_valid", bus.out_valid, m_done);
    chk("overflow",  bus.overflow,  m_ovf);
    chk("out_hold",  bus.out,       m_out);
  endtask

  // one clock: inputs applied at the falling edge, checked at the next one
  task automatic cycle(input bit dv, input int d, input bit s, input bit en, input bit cl);
    bus.digit_valid = dv;
    bus.digit       = d[3:0];
    bus.sign        = s;
    bus.enter       = en;
    bus.clear       = cl;
    @(posedge clk);
    model_step(dv, d, s, en, cl);
    @(negedge clk);
    bus.digit_valid = 1'b0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
    check_state();
  endtask

  task automatic do_reset(input bit dv, input int d);
    reset_n         = 1'b0;
    bus.digit_valid = dv;
    bus.digit       = d[3:0];
    @(posedge clk);
    m_cnt = 0; m_mag = 0; m_conv = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_out = 8'h00;
    exp_q.delete();
    @(negedge clk);
    reset_n         = 1'b1;
    bus.digit_valid = 1'b0;
    check_state();
  endtask

  task automatic send(input int d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ent(input bit s);
    cycle(1'b0, 0, s, 1'b1, 1'b0);
  endtask

  task automatic clr();
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // monitor: every new result is popped from the scoreboard and compared
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [8:0] r;
    if (bus.out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        r = exp_q.pop_front();
        chk("result_out", bus.out, r[7:0]);
        chk("result_ovf", bus.overflow, r[8]);
      end
    end
    prev_valid = bus.out_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    reset_n         = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.sign        = 1'b0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
    @(negedge clk);
    do_reset(1'b0, 0);

    send(1); send(2); send(7); ent(1'b0); idle(2); clr();          // 127
    send(1); send(2); send(8); ent(1'b1); idle(2); clr();          // -128
    send(1); send(2); send(8); ent(1'b0); idle(2); clr();          // overflow
    send(5); ent(1'b1); idle(2); clr();                            // -5
    send(0); ent(1'b1); idle(2); clr();                            // -0
    ent(1'b0); idle(2); clr();                                     // no digits
    send(9); send(9); send(9); send(4); send(10); ent(1'b1); idle(2); clr();
    send(3); cycle(1'b0, 0, 1'b0, 1'b1, 1'b1); idle(2);            // clear+enter
    send(4); send(2); cycle(1'b1, 5, 1'b0, 1'b1, 1'b0); idle(2);   // 42
    ent(1'b1); idle(1);                                            // enter in DONE
    send(7); idle(1); ent(1'b0); idle(2); clr();                   // restart in DONE
    send(6); send(3); do_reset(1'b1, 1); ent(1'b0); idle(2); clr();
    send(1); ent(1'b0); do_reset(1'b0, 0); idle(3);                // reset in CONVERT

    for (int i = 0; i < 3000; i++) begin
      op = $urandom_range(0, 99);
      if (op < 55)      send($urandom_range(0, 11));
      else if (op < 68) ent($urandom_range(0, 1));
      else if (op < 76) clr();
      else if (op < 78) do_reset($urandom_range(0, 1), $urandom_range(0, 9));
      else if (op < 86) cycle($urandom_range(0, 1), $urandom_range(0, 15),
                              $urandom_range(0, 1), $urandom_range(0, 1),
                              $urandom_range(0, 1));
      else              idle(1);
    end
    idle(3);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_to_comp2.md
# bcd_to_comp2

Sequential decimal-entry encoder. It accepts up to three BCD digits, one per strobe, plus a sign bit, and accumulates their magnitude. On an enter command it range-checks the magnitude and emits the 8-bit two's-complement value, negating with invert-plus-one. It sits on the input side of the calculator datapath, between the digit entry logic and the ULA operand registers. It is the inverse of the two's-complement-to-magnitude display path.

## Interface
Parameters: none (width fixed at 8-bit result, 3 digits).

- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous reset, active-low
- digit_valid  input  1  one-cycle strobe: digit is presented
- digit  input  4  BCD digit, legal 0-9
- sign  input  1  1 = negative; sampled only on the enter cycle
- enter  input  1  one-cycle strobe: finish entry and convert
- clear  input  1  one-cycle strobe: abort entry, return to IDLE
- out  output  8  two's-complement result
- out_valid  output  1  high while out holds a completed conversion
- overflow  output  1  high with out_valid when the magnitude is outside -128..127
- busy  output  1  high during CONVERT
- ndigits  output  2  number of digits accepted so far (0-3)

Reset is synchronous and active-low. reset_n is sampled on the rising edge of clk, the single clock.

## Operation
- Internal state: acc (10 bits, max 999), cnt (2 bits), sgn (1 bit), FSM state.
- FSM states:
  - IDLE: acc=0, cnt=0.
  - ACCUM: digits being collected.
  - CONVERT: one cycle.
  - DONE: result held.
- Priority within a cycle: reset_n low > clear > enter > digit_valid. Lower-priority strobes in the same cycle are dropped.
- Digit accept, in IDLE or ACCUM, when digit_valid=1, digit<=9 and cnt<3:
  - acc <= (acc<<3) + (acc<<1) + digit.
  - cnt <= cnt+1.
  - state <= ACCUM.
- Ignored digits (no state change): digit>9, a 4th or later digit, or any digit during CONVERT.
- enter, in IDLE or ACCUM: sgn <= sign, state <= CONVERT. enter with zero digits converts acc=0.
- CONVERT, on the next edge:
  - overflow = (sgn=0 and acc>127) or (sgn=1 and acc>128).
  - If overflow: out <= 8'h00.
  - Otherwise: out <= sgn ? (~acc[7:0])+1 : acc[7:0]. Result is 8 bits with carry discarded, so -0 gives 8'h00 and -128 gives 8'h80.
  - out_valid <= 1, state <= DONE.
- DONE: out, out_valid and overflow are held.
  - clear: go to IDLE, drop out_valid and overflow. out keeps its last value.
  - Legal digit_valid: start a new number. acc <= digit, cnt <= 1, go to ACCUM, drop out_valid and overflow.
  - enter in DONE is ignored.
- clear in any state: go to IDLE with acc=0, cnt=0, out_valid=0, overflow=0.
- enter and clear are ignored during CONVERT. CONVERT always completes.

## Timing
- Reset values: out=8'h00, out_valid=0, overflow=0, busy=0, ndigits=0, state IDLE.
- Digit accepted at edge k: ndigits and acc are updated after edge k.
- Latency: enter sampled at edge k moves the FSM to CONVERT. busy=1 from after edge k until edge k+1. At edge k+1, out, overflow and out_valid=1 are registered. Total: 2 edges from enter to a valid result.
- Throughput: one digit per cycle. Back-to-back digit_valid is legal.
- reset_n low on any edge, including mid-ACCUM or during CONVERT: all state returns to reset values on that edge. No partial result is emitted.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Digits 1,2,7 with sign=0, then enter: 2 edges later out=8'h7F, out_valid=1, overflow=0.
- Digits 1,2,8 with sign=1, then enter: out=8'h80, overflow=0. Same digits with sign=0: overflow=1, out=8'h00.
- Digit 5 with sign=1: out=8'hFB. Digit 0 with sign=1: out=8'h00. enter with no digits: out=8'h00.
- Digits 9,9,9,4 and digit 4'hA: ndigits stays at 3, and 4'hA is ignored. sign=1 then enter gives overflow=1 and out=8'h00.
- Simultaneous strobes:
  - clear and enter in the same cycle: IDLE, out_valid stays 0.
  - enter and digit_valid in the same cycle: the digit is dropped, and digits 4,2 convert to 8'h2A.
  - digit_valid=7 in DONE: out_valid drops, ndigits=1. Then enter gives out=8'h07.
- reset_n low mid-ACCUM after digits 6,3: ndigits=0. A following enter gives out=8'h00. reset_n during CONVERT: out_valid never rises.
